// File: rtl/sequence_pkg.sv
// sequence_pkg: word markers and FSM state type for the sequence tracker
package sequence_pkg;
  localparam logic [1:0] HDR_MARK = 2'b10;
  localparam logic [1:0] PAY_MARK = 2'b01;
  typedef enum logic {HUNT, COLLECT} state_t;
endpackage

// File: rtl/sequence_word_assembler.sv
// sequence_word_assembler: MSB-first byte shift register with byte counter, key is the value including the byte being shifted
module sequence_word_assembler #(
  parameter int KEY_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 shift,
  input  logic [7:0]           data,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 done
);
  localparam int NB = KEY_WIDTH / 8;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [KEY_WIDTH+7:0] joined;
  logic [3:0] cnt_q, cnt_d;
  always_comb begin
    joined = {key_q, data};
    key = joined[KEY_WIDTH-1:0];
    done = shift && cnt_q == 4'(NB - 1);
    key_d = clear ? '0 : shift ? key : key_q;
    cnt_d = clear ? 4'd0 : shift ? (done ? 4'd0 : cnt_q + 4'd1) : cnt_q;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      key_q <= '0;
      cnt_q <= 4'd0;
    end else begin
      key_q <= key_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/sequence_tracker.sv
// sequence_tracker: frames header+payload words into keys and publishes a key once seen in enough consecutive frames
module sequence_tracker
  import sequence_pkg::*;
#(
  parameter int         KEY_WIDTH     = 32,
  parameter logic [7:0] ID            = 8'hA5,
  parameter int         CONFIRM_COUNT = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [9:0]           sequence_in,
  input  logic                 sequence_valid,
  output logic [KEY_WIDTH-1:0] sequence_out,
  output logic                 ready,
  output logic                 frame_error,
  output logic [3:0]           confirm_level
);
  localparam logic [3:0] CC = 4'(CONFIRM_COUNT);
  state_t state_q, state_d;
  logic is_hdr, is_pay, is_oth, shift, done, match;
  logic [KEY_WIDTH-1:0] key, cand_q, cand_d, out_q, out_d;
  logic [3:0] lvl_q, lvl_d;
  logic ready_q, ready_d, err_q, err_d;
  always_comb begin
    is_hdr = sequence_valid && sequence_in[9:8] == HDR_MARK && sequence_in[7:0] == ID;
    is_pay = sequence_valid && sequence_in[9:8] == PAY_MARK;
    is_oth = sequence_valid && !is_hdr && !is_pay;
    shift = state_q == COLLECT && is_pay;
  end
  sequence_word_assembler #(.KEY_WIDTH(KEY_WIDTH)) u_asm (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (is_hdr),
    .shift   (shift),
    .data    (sequence_in[7:0]),
    .key     (key),
    .done    (done)
  );
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= HUNT;
      cand_q <= '0;
      out_q <= '0;
      lvl_q <= 4'd0;
      ready_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q <= cand_d;
      out_q <= out_d;
      lvl_q <= lvl_d;
      ready_q <= ready_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    state_d = state_q == HUNT ? (is_hdr ? COLLECT : HUNT)
            : is_hdr ? COLLECT : (is_oth || done) ? HUNT : COLLECT;
  end
  always_comb begin
    match = key == cand_q;
    err_d = state_q == COLLECT && (is_hdr || is_oth);
    cand_d = done ? key : cand_q;
    lvl_d = !done ? lvl_q : !match ? 4'd1 : lvl_q < CC ? lvl_q + 4'd1 : lvl_q;
    ready_d = done ? lvl_d == CC : ready_q;
    out_d = (done && lvl_d == CC) ? key : out_q;
  end
  assign sequence_out = out_q;
  assign ready = ready_q;
  assign frame_error = err_q;
  assign confirm_level = lvl_q;
endmodule

// File: doc/sequence_tracker.md
SEQUENCE_TRACKER -- requirements
Module: sequence_tracker

Interface
REQ-001 The module SHALL have parameter KEY_WIDTH, default 32, meaning key length in bits; legal values are multiples of 8 in the range 8..64.
REQ-002 The module SHALL have parameter ID, default 8'hA5, meaning the 8-bit identifier expected in the header word.
REQ-003 The module SHALL have parameter CONFIRM_COUNT, default 2, meaning the number of consecutive identical frames required for lock; legal range is 1..15.
REQ-004 Port clock, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-005 Port reset_n, input, 1 bit: reset that is synchronous and active-low.
REQ-006 Port sequence_in, input, 10 bits: decoder stream word.
REQ-007 Port sequence_valid, input, 1 bit: sequence_in is sampled only when this is 1.
REQ-008 Port sequence_out, output, KEY_WIDTH bits: the confirmed key.
REQ-009 Port ready, output, 1 bit: level signal, 1 while sequence_out holds a confirmed key.
REQ-010 Port frame_error, output, 1 bit: one-cycle pulse on an aborted frame.
REQ-011 Port confirm_level, output, 4 bits: current count of consecutive matching frames.

Function
REQ-012 Word classes SHALL be decoded as follows: header is sequence_in[9:8]=2'b10 with [7:0]=ID; payload is [9:8]=2'b01 carrying data in [7:0]; all other words are "other".
REQ-013 A frame SHALL consist of one header followed by NB=KEY_WIDTH/8 payload words; data SHALL be assembled MSB-first, with the first payload word forming key bits [KEY_WIDTH-1:KEY_WIDTH-8].
REQ-014 The FSM SHALL have two states, HUNT and COLLECT; reset state is HUNT.
REQ-015 In HUNT, a valid header SHALL cause a transition to COLLECT and clear the byte counter; all other valid words SHALL be ignored without error.
REQ-016 In COLLECT, a valid payload word SHALL shift into the assembly register and increment the byte counter.
REQ-017 When the NB-th payload word is accepted, the FSM SHALL return to HUNT and evaluate the frame in the same cycle.
REQ-018 In COLLECT, a valid header SHALL pulse frame_error, discard partial data, and restart COLLECT with the byte counter cleared.
REQ-019 In COLLECT, a valid "other" word SHALL pulse frame_error and return the FSM to HUNT.
REQ-020 Words with sequence_valid=0 SHALL have no effect in any state; gaps within a frame are permitted.
REQ-021 Aborted frames SHALL NOT change the candidate register, confirm_level, ready, or sequence_out.
REQ-022 On frame completion with assembled key equal to the candidate and confirm_level < CONFIRM_COUNT, confirm_level SHALL increment; at CONFIRM_COUNT it SHALL saturate.
REQ-023 On frame completion with assembled key different from the candidate, the candidate SHALL be loaded with the key and confirm_level SHALL be set to 1.
REQ-024 A differing complete frame SHALL deassert ready in the cycle after completion; sequence_out SHALL retain its old value.
REQ-025 When confirm_level reaches CONFIRM_COUNT, sequence_out SHALL be loaded with the candidate and ready SHALL assert one cycle after the final payload word is accepted.
REQ-026 With CONFIRM_COUNT=1, the first complete frame SHALL assert ready.
REQ-027 Re-confirmation of the same key SHALL keep ready at 1 with no glitch.
REQ-028 frame_error SHALL be registered, appearing the cycle after the offending word.

Reset
REQ-029 When reset_n=0 at a rising clock edge, the design SHALL set state=HUNT, byte counter=0, candidate=0, confirm_level=0, sequence_out=0, ready=0, and frame_error=0.
REQ-030 A reset during COLLECT SHALL discard the partial frame with no frame_error pulse.

Structure
REQ-031 The package sequence_pkg SHALL hold the marker constants HDR_MARK=2'b10 and PAY_MARK=2'b01, and the state enum {HUNT, COLLECT}.
REQ-032 The shift register and byte counter SHALL be the sub-module sequence_word_assembler (parameter KEY_WIDTH; outputs key and done).
REQ-033 The top level SHALL contain the FSM, the compare/confirm logic, and the output registers.

Verification
REQ-034 The bench SHALL cover: KEY_WIDTH=32 with two frames of header 0x2A5, payloads 0x1DE,0x1AD,0x1BE,0x1EF -> after the 2nd frame, ready=1 and sequence_out=0xDEADBEEF at latency 1.
REQ-035 The bench SHALL cover: a locked 0xDEADBEEF followed by frame key 0x01020304 -> ready=0 with sequence_out unchanged, then a second 0x01020304 frame -> ready=1 and sequence_out=0x01020304.
REQ-036 The bench SHALL cover: a header, two payloads, then word 0x3FF -> one-cycle frame_error, with confirm_level, ready, and sequence_out unchanged.
REQ-037 The bench SHALL cover: a header, one payload, then a header plus four payloads -> frame_error once, with the second frame counted (confirm_level=1).
REQ-038 The bench SHALL cover: a frame with sequence_valid low between every word -> result identical to the gapless frame.
REQ-039 The bench SHALL cover: reset_n=0 asserted mid-frame while locked -> all outputs 0 next cycle, no frame_error, and relock requiring CONFIRM_COUNT full frames.
